// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared memory-access definitions: mem_op size encodings, mem_op bit indices,
// sequencer state encoding and access-classification helpers.
package mem_defs;

   localparam int MEMOP_WEN = 4;
   localparam int MEMOP_REN = 3;

   typedef enum logic [2:0] {
      MEM_B    = 3'b000,
      MEM_H    = 3'b001,
      MEM_W    = 3'b010,
      MEM_BU   = 3'b100,
      MEM_HU   = 3'b101,
      MEM_NONE = 3'b111
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Unlisted encodings (011, 110) are rejected like MEM_NONE.
   function automatic logic size_ok(input logic [2:0] size, input logic is_store);
      logic ok_s;
      case (size)
         MEM_B, MEM_H, MEM_W: ok_s = 1'b1;
         MEM_BU, MEM_HU:      ok_s = ~is_store;
         default:             ok_s = 1'b0;
      endcase
      return ok_s;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic mis_s;
      case (size)
         MEM_H, MEM_HU: mis_s = addr_lo[0];
         MEM_W:         mis_s = (addr_lo != 2'b00);
         default:       mis_s = 1'b0;
      endcase
      return mis_s;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory port bundle: req/gnt/rvalid handshake plus address, lanes and data.
interface lsu_mem_ctrl_if #(parameter int AW = 32);

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated store data for a request,
// lane extraction with sign/zero extension for a load response.
module lsu_lane_align
   import mem_defs::*;
(
   input  logic [2:0]  req_size,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [2:0]  rsp_size,
   input  logic [1:0]  rsp_addr_lo,
   input  logic [31:0] rsp_rdata,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Request side: lane enables and store-data replication
   always_comb begin
      be    = 4'b0000;
      wdata = 32'h0000_0000;
      case (req_size)
         MEM_B, MEM_BU: begin
            be    = 4'b0001 << req_addr_lo;
            wdata = {4{req_wdata[7:0]}};
         end
         MEM_H, MEM_HU: begin
            be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{req_wdata[15:0]}};
         end
         MEM_W: begin
            be    = 4'b1111;
            wdata = req_wdata;
         end
         default: begin
            be    = 4'b0000;
            wdata = 32'h0000_0000;
         end
      endcase
   end

   // Response side: pick the addressed byte lane
   always_comb begin
      byte_s = 8'h00;
      case (rsp_addr_lo)
         2'd0:    byte_s = rsp_rdata[7:0];
         2'd1:    byte_s = rsp_rdata[15:8];
         2'd2:    byte_s = rsp_rdata[23:16];
         2'd3:    byte_s = rsp_rdata[31:24];
         default: byte_s = 8'h00;
      endcase
   end

   // Halfwords ignore addr[0]; only addr[1] selects the lane pair
   assign half_s = rsp_addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];

   // Response side: extension by access size
   always_comb begin
      rdata_ext = 32'h0000_0000;
      case (rsp_size)
         MEM_B:   rdata_ext = {{24{byte_s[7]}}, byte_s};
         MEM_BU:  rdata_ext = {24'h00_0000, byte_s};
         MEM_H:   rdata_ext = {{16{half_s[15]}}, half_s};
         MEM_HU:  rdata_ext = {16'h0000, half_s};
         MEM_W:   rdata_ext = rsp_rdata;
         default: rdata_ext = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between EX/MEM and the data memory port.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module lsu_mem_ctrl
   import mem_defs::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ex_valid_i,
   input  logic [4:0]    mem_op_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic          stall_o,
   output logic          done_o,
   output logic [DW-1:0] rdata_o,
   output logic          misalign_o,
   lsu_mem_ctrl_if.master mem
);

   lsu_state_e    state_r;
   lsu_state_e    state_nxt_s;

   logic          w_en_s;
   logic          r_en_s;
   logic [2:0]    size_s;
   logic          start_s;
   logic          accept_s;
   logic          misalign_s;
   logic          bad_s;
   logic          stall_s;

   logic          we_r;
   logic [2:0]    size_r;
   logic [1:0]    addr_lo_r;

   logic          req_r;
   logic          mem_we_r;
   logic [AW-1:0] addr_r;
   logic [3:0]    be_r;
   logic [DW-1:0] wdata_r;
   logic [DW-1:0] rdata_r;
   logic          done_r;
   logic          misalign_r;

   logic [3:0]    be_s;
   logic [31:0]   wdata_al_s;
   logic [31:0]   rdata_ext_s;

   assign w_en_s   = mem_op_i[MEMOP_WEN];
   assign r_en_s   = mem_op_i[MEMOP_REN];
   assign size_s   = mem_op_i[2:0];
   assign start_s  = ex_valid_i & (w_en_s ^ r_en_s);
   assign accept_s = start_s & ((state_r == ST_IDLE) | (state_r == ST_DONE));

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_s = is_misaligned(size_s, addr_i[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   // Rejected accesses complete without touching memory
   assign bad_s = ~size_ok(size_s, w_en_s) | misalign_s;

   lsu_lane_align u_align (
      .req_size    (size_s),
      .req_addr_lo (addr_i[1:0]),
      .req_wdata   (wdata_i),
      .be          (be_s),
      .wdata       (wdata_al_s),
      .rsp_size    (size_r),
      .rsp_addr_lo (addr_lo_r),
      .rsp_rdata   (mem.mem_rdata),
      .rdata_ext   (rdata_ext_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and stall decode
   always_comb begin
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            stall_s = start_s;
            if (accept_s) begin
               state_nxt_s = bad_s ? ST_DONE : ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            stall_s = 1'b1;
            if (mem.mem_gnt) begin
               state_nxt_s = we_r ? ST_DONE : ST_RESP;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_RESP: begin
            stall_s = ~mem.mem_rvalid;
            if (mem.mem_rvalid) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         ST_DONE: begin
            stall_s = 1'b0;
            if (accept_s) begin
               state_nxt_s = bad_s ? ST_DONE : ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            stall_s     = 1'b0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Request latch and registered bus/result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r       <= 1'b0;
         size_r     <= 3'b000;
         addr_lo_r  <= 2'b00;
         req_r      <= 1'b0;
         mem_we_r   <= 1'b0;
         addr_r     <= {AW{1'b0}};
         be_r       <= 4'b0000;
         wdata_r    <= {DW{1'b0}};
         rdata_r    <= {DW{1'b0}};
         done_r     <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         done_r <= (state_nxt_s == ST_DONE);
         if (accept_s) begin
            we_r       <= w_en_s;
            size_r     <= size_s;
            addr_lo_r  <= addr_i[1:0];
            req_r      <= ~bad_s;
            mem_we_r   <= w_en_s & ~bad_s;
            addr_r     <= bad_s ? {AW{1'b0}} : {addr_i[AW-1:2], 2'b00};
            be_r       <= bad_s ? 4'b0000 : be_s;
            wdata_r    <= (bad_s | ~w_en_s) ? {DW{1'b0}} : wdata_al_s;
            rdata_r    <= {DW{1'b0}};
            misalign_r <= misalign_s;
         end else if ((state_r == ST_REQ) && mem.mem_gnt) begin
            req_r    <= 1'b0;
            mem_we_r <= 1'b0;
            addr_r   <= {AW{1'b0}};
            be_r     <= 4'b0000;
            wdata_r  <= {DW{1'b0}};
         end else if ((state_r == ST_RESP) && mem.mem_rvalid) begin
            rdata_r <= rdata_ext_s;
         end else if (state_r == ST_DONE) begin
            rdata_r    <= {DW{1'b0}};
            misalign_r <= 1'b0;
         end
      end
   end

   assign stall_o       = stall_s;
   assign done_o        = done_r;
   assign rdata_o       = rdata_r;
   assign misalign_o    = misalign_r;
   assign mem.mem_req   = req_r;
   assign mem.mem_we    = mem_we_r;
   assign mem.mem_addr  = addr_r;
   assign mem.mem_be    = be_r;
   assign mem.mem_wdata = wdata_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl (default build): directed cases, reset
// mid-access, then randomized loads/stores against a behavioural model.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [4:0]  mem_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        misalign;

   always #5 clk = ~clk;

   lsu_mem_ctrl_if #(.AW(32)) mif ();

   lsu_mem_ctrl #(.AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_valid_i (ex_valid),
      .mem_op_i   (mem_op),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .stall_o    (stall),
      .done_o     (done),
      .rdata_o    (rdata),
      .misalign_o (misalign),
      .mem        (mif)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      bit          chk_rd;
      logic [31:0] rdata;
   } rsp_t;

   req_t        req_q[$];
   rsp_t        exp_q[$];
   int          gdly_q[$];
   int          rvdly_q[$];
   logic [31:0] word_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   bit in_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_be(input logic [2:0] sz, input logic [31:0] a);
      int unsigned k;
      if (sz == 3'b010) return 4'hF;
      if (sz == 3'b001 || sz == 3'b101) begin
         k = (a / 2) % 2;
         return (k == 1) ? 4'b1100 : 4'b0011;
      end
      k = a % 4;
      return 4'(1 << k);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] w);
      if (sz == 3'b000) return (w & 32'hFF) * 32'h0101_0101;
      if (sz == 3'b001) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a,
                                            input logic [31:0] w);
      int unsigned k;
      longint      v;
      case (sz)
         3'b000, 3'b100: begin
            k = a % 4;
            v = longint'((w >> (8 * k)) & 32'hFF);
            if (sz == 3'b000 && v >= 128) v = v - 256;
         end
         3'b001, 3'b101: begin
            k = (a / 2) % 2;
            v = longint'((w >> (16 * k)) & 32'hFFFF);
            if (sz == 3'b001 && v >= 32768) v = v - 65536;
         end
         3'b010:  v = longint'(w);
         default: v = 0;
      endcase
      return v[31:0];
   endfunction

   task automatic push_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] word, input int gdly, input int rvdly);
      bit   ld, st, bad;
      req_t r;
      rsp_t e;
      ld  = op[3] & ~op[4];
      st  = op[4] & ~op[3];
      bad = (op[2:0] == 3'b111) || (st && op[2]);
      if (!bad) begin
         r.we    = st;
         r.addr  = a & 32'hFFFF_FFFC;
         r.be    = ref_be(op[2:0], a);
         r.wdata = ref_wdata(op[2:0], wd);
         req_q.push_back(r);
         gdly_q.push_back(gdly);
         if (ld) begin
            rvdly_q.push_back(rvdly);
            word_q.push_back(word);
         end
      end
      e.chk_rd = ld | bad;
      e.rdata  = (ld && !bad) ? ref_load(op[2:0], a, word) : 32'h0;
      exp_q.push_back(e);
   endtask

   // ---------------- memory model ----------------
   int gcnt;
   bit ghave;
   int rvcnt;
   bit rvpend;

   initial begin
      ghave = 1'b0;
      rvpend = 1'b0;
      gcnt = 0;
      rvcnt = 0;
      mif.mem_gnt    = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         mif.mem_gnt    = 1'b0;
         mif.mem_rvalid = 1'b0;
         mif.mem_rdata  = $urandom;
         if (rvpend) begin
            if (rvcnt == 0) begin
               mif.mem_rvalid = 1'b1;
               mif.mem_rdata  = (word_q.size() > 0) ? word_q.pop_front() : 32'h0;
               rvpend = 1'b0;
            end else begin
               rvcnt--;
            end
         end else if (mif.mem_req === 1'b1) begin
            if (!ghave) begin
               gcnt  = (gdly_q.size() > 0) ? gdly_q.pop_front() : 0;
               ghave = 1'b1;
            end
            if (gcnt == 0) begin
               mif.mem_gnt = 1'b1;
               ghave = 1'b0;
               if (mif.mem_we === 1'b0) begin
                  rvpend = 1'b1;
                  rvcnt  = (rvdly_q.size() > 0) ? rvdly_q.pop_front() : 0;
               end
            end else begin
               gcnt--;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   rsp_t mon_e;

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", {31'b0, done}, 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("stall_in_done", {31'b0, stall}, 32'h0);
               chk("misalign", {31'b0, misalign}, 32'h0);
               if (mon_e.chk_rd) chk("rdata", rdata, mon_e.rdata);
            end
         end
         if (mif.mem_req) begin
            if (req_q.size() == 0) begin
               chk("spurious_req", {31'b0, mif.mem_req}, 32'h0);
            end else begin
               chk("mem_we", {31'b0, mif.mem_we}, {31'b0, req_q[0].we});
               chk("mem_addr", mif.mem_addr, req_q[0].addr);
               chk("mem_be", {28'b0, mif.mem_be}, {28'b0, req_q[0].be});
               if (req_q[0].we) chk("mem_wdata", mif.mem_wdata, req_q[0].wdata);
               if (mif.mem_gnt) void'(req_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_access(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] word, input int gdly, input int rvdly,
                            input bit chain);
      bit ld, st, bad;
      int exp_lat, cnt;
      ld  = op[3] & ~op[4];
      st  = op[4] & ~op[3];
      bad = (op[2:0] == 3'b111) || (st && op[2]);
      push_exp(op, a, wd, word, gdly, rvdly);
      exp_lat = bad ? 0 : (st ? 1 + gdly : 2 + gdly + rvdly);
      ex_valid = 1'b1;
      mem_op   = op;
      addr     = a;
      wdata    = wd;
      #1;
      if (!in_done) chk("stall_accept", {31'b0, stall}, 32'h1);
      @(posedge clk);
      #2;
      ex_valid = 1'b0;
      cnt = 0;
      while (!done && cnt < 100) begin
         @(posedge clk);
         #2;
         cnt++;
      end
      chk("latency", cnt, exp_lat);
      in_done = chain;
      if (!chain) begin
         @(posedge clk);
         #2;
         chk("done_pulse", {31'b0, done}, 32'h0);
      end
   endtask

   task automatic no_access(input logic [4:0] op, input logic [31:0] a);
      ex_valid = 1'b1;
      mem_op   = op;
      addr     = a;
      #1;
      chk("noacc_stall", {31'b0, stall}, 32'h0);
      @(posedge clk);
      #2;
      ex_valid = 1'b0;
      chk("noacc_done", {31'b0, done}, 32'h0);
      chk("noacc_req", {31'b0, mif.mem_req}, 32'h0);
      in_done = 1'b0;
   endtask

   logic [4:0]  r_op;
   logic [31:0] r_addr;
   int          r_kind;

   initial begin
      rst_n    = 1'b0;
      ex_valid = 1'b0;
      mem_op   = 5'b00111;
      addr     = 32'h0;
      wdata    = 32'h0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_req", {31'b0, mif.mem_req}, 32'h0);
      chk("rst_be", {28'b0, mif.mem_be}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // directed cases
      do_access(5'b01010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0); // LW
      do_access(5'b01000, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, 0, 1'b0); // LB
      do_access(5'b01100, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 1, 1'b0); // LBU
      do_access(5'b10001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 0, 1'b0); // SH
      do_access(5'b01001, 32'h0000_0306, 32'h0, 32'h9876_5432, 0, 0, 1'b0); // LH hi
      do_access(5'b01010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b1); // LW misaligned
      do_access(5'b10000, 32'h0000_0007, 32'h0000_005A, 32'h0, 0, 0, 1'b0); // SB back-to-back
      no_access(5'b11010, 32'h0000_0100);
      no_access(5'b00010, 32'h0000_0100);
      do_access(5'b01111, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 1'b0);         // size none
      do_access(5'b10100, 32'h0000_0040, 32'h1111_1111, 32'h0, 0, 0, 1'b1); // store BU
      do_access(5'b10010, 32'h0000_0044, 32'hA5A5_0F0F, 32'h0, 2, 0, 1'b0); // SW chained

      // reset asserted while waiting for read data
      push_exp(5'b01010, 32'h0000_0040, 32'h0, 32'h1122_3344, 0, 5);
      ex_valid = 1'b1;
      mem_op   = 5'b01010;
      addr     = 32'h0000_0040;
      @(posedge clk);
      #2;
      ex_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("resp_stall", {31'b0, stall}, 32'h1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_stall", {31'b0, stall}, 32'h0);
      chk("arst_done", {31'b0, done}, 32'h0);
      chk("arst_req", {31'b0, mif.mem_req}, 32'h0);
      chk("arst_rdata", rdata, 32'h0);
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #2;
         chk("post_rst_done", {31'b0, done}, 32'h0);
      end
      in_done = 1'b0;

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         r_kind = $urandom_range(0, 9);
         r_addr = $urandom;
         case (r_kind)
            0, 1, 2, 3, 4: begin
               case ($urandom_range(0, 4))
                  0:       r_op = 5'b01000;
                  1:       r_op = 5'b01001;
                  2:       r_op = 5'b01010;
                  3:       r_op = 5'b01100;
                  default: r_op = 5'b01101;
               endcase
            end
            5, 6, 7: begin
               case ($urandom_range(0, 2))
                  0:       r_op = 5'b10000;
                  1:       r_op = 5'b10001;
                  default: r_op = 5'b10010;
               endcase
            end
            8: begin
               case ($urandom_range(0, 3))
                  0:       r_op = 5'b01111;
                  1:       r_op = 5'b10111;
                  2:       r_op = 5'b10100;
                  default: r_op = 5'b10101;
               endcase
            end
            default: begin
               r_op = ($urandom_range(0, 1) == 1) ? 5'b11000 : 5'b00000;
               r_op[2:0] = 3'($urandom_range(0, 7));
            end
         endcase
         if (r_kind == 9) begin
            no_access(r_op, r_addr);
         end else begin
            do_access(r_op, r_addr, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
         end
      end
      if (in_done) begin
         @(posedge clk);
         #2;
      end
      repeat (3) @(posedge clk);
      #2;
      chk("exp_q_drained", exp_q.size(), 32'h0);
      chk("req_q_drained", req_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
